stopwatch_timebase: RTL and testbench
=====================================

# stopwatch_timebase

Front end of the stopwatch datapath. It turns start/stop/reset button levels into a run/pause/idle control state, divides the system clock down to a 1 s tick, and counts seconds 0–59. It drives the minutes stage directly: `min_tick` is the minutes-stage enable and `clear` is the minutes-stage clear.

## Interface
Parameters:
- `CYCLES_PER_SEC`, default 100_000_000: clk cycles per counted second. Must be ≥ 2. The prescaler width is derived from it with `$clog2`.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `start_btn`  in  1  start/resume request, already synchronised level; acts on its rising edge.
- `stop_btn`  in  1  pause request, level; acts on its rising edge.
- `reset_btn`  in  1  clear request, level; acts on its rising edge.
- `seconds`  out  8  current seconds, 0–59.
- `min_tick`  out  1  one-cycle pulse on the 59→0 wrap; feeds the minutes `enable`.
- `clear`  out  1  one-cycle pulse on an accepted reset request; feeds the minutes `clear`.
- `running`  out  1  high while in RUNNING.
- `state`  out  2  FSM state: IDLE=2'b00, RUNNING=2'b01, PAUSED=2'b10.

## Operation
- **Edge detect:** one previous-value register per button. An edge is `btn & ~prev`. The prev registers reset to 1, so a button held through reset is ignored until it is released and pressed again.
- **Priority in one cycle:** reset edge > stop edge > start edge. Only the highest-priority edge acts; the others are discarded.
- **FSM transitions:**
  - IDLE: start → RUNNING; reset → IDLE with `clear`; stop ignored.
  - RUNNING: reset → IDLE with `clear`; stop → PAUSED; start ignored.
  - PAUSED: reset → IDLE with `clear`; start → RUNNING; stop ignored.
  - State encoding 2'b11 is unreachable; if entered, go to IDLE.
- **Prescaler** (0 … CYCLES_PER_SEC-1):
  - Increments only in a RUNNING cycle with no stop or reset edge.
  - At CYCLES_PER_SEC-1 it returns to 0 and `seconds` advances.
  - Holds its value in PAUSED, so resume continues the partial second.
  - Forced to 0 on entry to IDLE.
- **Seconds:**
  - +1 per prescaler terminal count.
  - At 59 it wraps to 0, and `min_tick` is 1 for that one cycle.
  - Never exceeds 59. Upper bits [7:6] are always 0.
- **Reset request:** on the same edge, `seconds` and the prescaler go to 0, `state` goes to IDLE, `clear` goes to 1 for one cycle, and `min_tick` goes to 0. The request suppresses any coincident tick.
- **Stop coincident with prescaler terminal count:** the stop wins. There is no advance, and the prescaler holds at CYCLES_PER_SEC-1, so the advance happens on the first RUNNING cycle after resume.
- **`rst_n` low (sampled at a clk edge):** seconds=0, prescaler=0, state=IDLE, running=0, min_tick=0, clear=0, prev regs=1. `rst_n` overrides everything, including button edges in the same cycle.

## Timing
- All outputs are registered. There is no combinational path from inputs to outputs.
- **Start:** an edge sampled at clock edge N puts `state`=RUNNING and `running`=1 after edge N.
- **First second:** the first increment of `seconds` occurs at edge N+CYCLES_PER_SEC.
- **`min_tick` alignment:** high during the cycle in which `seconds` reads 0 after the wrap, exactly one cycle wide. The minutes counter samples it on the next edge, so minutes update one cycle after `seconds` shows 0.
- **`clear` alignment:** high for the single cycle after the accepted reset edge. The minutes counter clears on the following edge.
- **Tick rate:** in continuous RUNNING, `min_tick` pulses exactly once every 60·CYCLES_PER_SEC cycles.

## Test plan
All scenarios use CYCLES_PER_SEC=4.

1. **Reset values:** hold `rst_n`=0 for 2 cycles with all buttons 0 → seconds=0, min_tick=0, clear=0, running=0, state=2'b00. Assert `rst_n` low between clock edges → no change until the next edge.
2. **Full minute:** start pulse, then 240 RUNNING cycles → seconds steps every 4 cycles through 0..59 and back to 0. Exactly one `min_tick` pulse, in the cycle seconds first reads 0 after 59. 480 cycles → exactly 2 pulses.
3. **Pause/resume:** run 10 cycles (seconds=2, prescaler=2), stop, wait 20 cycles → seconds stays 2, running=0, state=2'b10. Start → seconds=3 exactly 2 cycles after entering RUNNING.
4. **Reset mid-run:** reset edge at seconds=37 → next cycle seconds=0, state=IDLE, `clear`=1 for exactly one cycle, min_tick=0. Reset edge at seconds=59 on the prescaler terminal count → no `min_tick`.
5. **Simultaneous edges:**
   - Start+stop+reset edges together in PAUSED → IDLE with `clear`.
   - Stop edge on the prescaler terminal count → seconds does not advance; after resume it advances on the first RUNNING cycle.
6. **Button levels:**
   - `start_btn` held high across `rst_n` deassertion → state stays IDLE; release then press → RUNNING.
   - `start_btn` held high 10 cycles → exactly one transition.
   - `stop_btn` in IDLE → no change.

Source files
------------

// File: rtl/stopwatch_timebase_if.sv
// Button levels in, seconds count and minutes-stage controls out.
interface stopwatch_timebase_if;
    logic       start_btn;
    logic       stop_btn;
    logic       reset_btn;
    logic [7:0] seconds;
    logic       min_tick;
    logic       clear;
    logic       running;
    logic [1:0] state;

    modport master (
        output start_btn, stop_btn, reset_btn,
        input  seconds, min_tick, clear, running, state
    );

    modport slave (
        input  start_btn, stop_btn, reset_btn,
        output seconds, min_tick, clear, running, state
    );
endinterface

// File: rtl/stopwatch_timebase.sv
// Stopwatch front end: button edge detect, run/pause/idle control,
// 1 s prescaler and 0..59 seconds counter driving the minutes stage.
//
// state   | meaning
// --------+-----------------------------------------------
// IDLE    | cleared, prescaler and seconds held at 0
// RUNNING | prescaler counting, seconds advancing
// PAUSED  | prescaler and seconds frozen, partial second kept
module stopwatch_timebase #(
    parameter int CYCLES_PER_SEC = 100_000_000
) (
    input logic                 clk,
    input logic                 rst_n,
    stopwatch_timebase_if.slave sw
);

    localparam int PW = (CYCLES_PER_SEC > 2) ? $clog2(CYCLES_PER_SEC) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(CYCLES_PER_SEC - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        RUNNING = 2'b01,
        PAUSED  = 2'b10
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [5:0]    sec_q, sec_d;
    logic          prev_start, prev_stop, prev_reset;
    logic          tick_q, tick_d;
    logic          clear_q, clear_d;
    logic          running_q;

    logic reset_e, stop_e, start_e;

    // Rising edges with reset > stop > start priority; lower ones are dropped.
    always_comb begin
        reset_e = sw.reset_btn & ~prev_reset;
        stop_e  = sw.stop_btn  & ~prev_stop  & ~reset_e;
        start_e = sw.start_btn & ~prev_start & ~reset_e & ~stop_e;
    end

    // Next state, prescaler/seconds update and pulse outputs.
    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        sec_d   = sec_q;
        tick_d  = 1'b0;
        clear_d = 1'b0;
        if (reset_e) begin
            state_d = IDLE;
            presc_d = '0;
            sec_d   = '0;
            clear_d = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_e) state_d = RUNNING;
                end
                RUNNING: begin
                    // A stop on terminal count leaves the prescaler at max,
                    // so the pending advance lands on the first cycle after resume.
                    if (stop_e) begin
                        state_d = PAUSED;
                    end else if (presc_q == PRESC_MAX) begin
                        presc_d = '0;
                        if (sec_q == 6'd59) begin
                            sec_d  = '0;
                            tick_d = 1'b1;
                        end else begin
                            sec_d = sec_q + 6'd1;
                        end
                    end else begin
                        presc_d = presc_q + PW'(1);
                    end
                end
                PAUSED: begin
                    if (start_e) state_d = RUNNING;
                end
                default: begin
                    state_d = IDLE;
                    presc_d = '0;
                    sec_d   = '0;
                end
            endcase
        end
    end

    // State and datapath registers; prev regs reset high so held buttons are ignored.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            presc_q    <= '0;
            sec_q      <= '0;
            tick_q     <= 1'b0;
            clear_q    <= 1'b0;
            running_q  <= 1'b0;
            prev_start <= 1'b1;
            prev_stop  <= 1'b1;
            prev_reset <= 1'b1;
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            sec_q      <= sec_d;
            tick_q     <= tick_d;
            clear_q    <= clear_d;
            running_q  <= (state_d == RUNNING);
            prev_start <= sw.start_btn;
            prev_stop  <= sw.stop_btn;
            prev_reset <= sw.reset_btn;
        end
    end

    assign sw.seconds  = {2'b00, sec_q};
    assign sw.min_tick = tick_q;
    assign sw.clear    = clear_q;
    assign sw.running  = running_q;
    assign sw.state    = state_q;

endmodule

// File: tb/tb_stopwatch_timebase.sv
// Directed bench for stopwatch_timebase with CYCLES_PER_SEC = 4.
module tb_stopwatch_timebase;

    localparam int CPS = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;

    stopwatch_timebase_if sw ();

    stopwatch_timebase #(.CYCLES_PER_SEC(CPS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sw    (sw.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       s, t, r;
        int         sec;
        logic [1:0] st;
        logic       run, mt, clr;
    } vec_t;

    vec_t tbl[41];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int sec, input logic [1:0] st,
                           input logic run, input logic mt, input logic clr);
        chk({tag, " seconds"},  32'(sw.seconds),  32'(sec));
        chk({tag, " state"},    32'(sw.state),    32'(st));
        chk({tag, " running"},  32'(sw.running),  32'(run));
        chk({tag, " min_tick"}, 32'(sw.min_tick), 32'(mt));
        chk({tag, " clear"},    32'(sw.clear),    32'(clr));
    endtask

    // Drive buttons in the low phase, sample 1 time unit after the rising edge.
    task automatic step(input logic s, input logic t, input logic r);
        @(negedge clk);
        sw.start_btn = s;
        sw.stop_btn  = t;
        sw.reset_btn = r;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        sw.start_btn = 1'b0;
        sw.stop_btn  = 1'b0;
        sw.reset_btn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int pulses;
        sw.start_btn = 1'b0;
        sw.stop_btn  = 1'b0;
        sw.reset_btn = 1'b0;

        tbl[0]  = '{0,0,0, 0,2'b00,0,0,0};
        tbl[1]  = '{0,1,0, 0,2'b00,0,0,0};
        tbl[2]  = '{0,0,0, 0,2'b00,0,0,0};
        tbl[3]  = '{1,0,0, 0,2'b01,1,0,0};
        tbl[4]  = '{1,0,0, 0,2'b01,1,0,0};
        tbl[5]  = '{0,0,0, 0,2'b01,1,0,0};
        tbl[6]  = '{0,0,0, 0,2'b01,1,0,0};
        tbl[7]  = '{0,0,0, 1,2'b01,1,0,0};
        tbl[8]  = '{0,0,0, 1,2'b01,1,0,0};
        tbl[9]  = '{0,0,0, 1,2'b01,1,0,0};
        tbl[10] = '{0,0,0, 1,2'b01,1,0,0};
        tbl[11] = '{0,0,0, 2,2'b01,1,0,0};
        tbl[12] = '{0,0,0, 2,2'b01,1,0,0};
        tbl[13] = '{0,0,0, 2,2'b01,1,0,0};
        tbl[14] = '{0,1,0, 2,2'b10,0,0,0};
        tbl[15] = '{0,1,0, 2,2'b10,0,0,0};
        tbl[16] = '{0,0,0, 2,2'b10,0,0,0};
        tbl[17] = '{1,0,0, 2,2'b01,1,0,0};
        tbl[18] = '{0,0,0, 2,2'b01,1,0,0};
        tbl[19] = '{0,0,0, 3,2'b01,1,0,0};
        tbl[20] = '{0,0,0, 3,2'b01,1,0,0};
        tbl[21] = '{0,0,0, 3,2'b01,1,0,0};
        tbl[22] = '{0,0,0, 3,2'b01,1,0,0};
        tbl[23] = '{0,1,0, 3,2'b10,0,0,0};
        tbl[24] = '{0,0,0, 3,2'b10,0,0,0};
        tbl[25] = '{1,0,0, 3,2'b01,1,0,0};
        tbl[26] = '{0,0,0, 4,2'b01,1,0,0};
        tbl[27] = '{0,0,1, 0,2'b00,0,0,1};
        tbl[28] = '{0,0,0, 0,2'b00,0,0,0};
        tbl[29] = '{1,0,0, 0,2'b01,1,0,0};
        tbl[30] = '{0,0,0, 0,2'b01,1,0,0};
        tbl[31] = '{0,1,0, 0,2'b10,0,0,0};
        tbl[32] = '{0,0,0, 0,2'b10,0,0,0};
        tbl[33] = '{1,1,1, 0,2'b00,0,0,1};
        tbl[34] = '{0,0,0, 0,2'b00,0,0,0};
        tbl[35] = '{1,0,0, 0,2'b01,1,0,0};
        tbl[36] = '{0,0,0, 0,2'b01,1,0,0};
        tbl[37] = '{1,1,0, 0,2'b10,0,0,0};
        tbl[38] = '{0,0,0, 0,2'b10,0,0,0};
        tbl[39] = '{0,0,1, 0,2'b00,0,0,1};
        tbl[40] = '{0,0,0, 0,2'b00,0,0,0};

        // Reset values after two low cycles.
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", 0, 2'b00, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table: idle stop, start, held start, pause/resume, stop on terminal
        // count, reset, simultaneous edges.
        for (int i = 0; i < 41; i++) begin
            step(tbl[i].s, tbl[i].t, tbl[i].r);
            chk_all($sformatf("vec%0d", i), tbl[i].sec, tbl[i].st,
                    tbl[i].run, tbl[i].mt, tbl[i].clr);
        end

        // Two full minutes of continuous running.
        do_reset();
        step(0, 0, 0);
        step(1, 0, 0);
        pulses = 0;
        for (int k = 1; k <= 480; k++) begin
            step(0, 0, 0);
            chk($sformatf("min k%0d seconds", k), 32'(sw.seconds), 32'((k / CPS) % 60));
            chk($sformatf("min k%0d min_tick", k), 32'(sw.min_tick), 32'(k % 240 == 0));
            if (sw.min_tick === 1'b1) pulses++;
        end
        chk("min_tick pulse count", 32'(pulses), 32'd2);

        // Reset request at seconds=37.
        do_reset();
        step(0, 0, 0);
        step(1, 0, 0);
        for (int k = 1; k <= 148; k++) step(0, 0, 0);
        chk("pre reset37 seconds", 32'(sw.seconds), 32'd37);
        step(0, 0, 1);
        chk_all("reset37", 0, 2'b00, 0, 0, 1);
        step(0, 0, 0);
        chk_all("reset37 after", 0, 2'b00, 0, 0, 0);

        // Reset request on the 59 terminal count suppresses min_tick.
        step(1, 0, 0);
        for (int k = 1; k <= 239; k++) step(0, 0, 0);
        chk("pre reset59 seconds", 32'(sw.seconds), 32'd59);
        step(0, 0, 1);
        chk_all("reset59", 0, 2'b00, 0, 0, 1);
        step(0, 0, 0);
        chk_all("reset59 after", 0, 2'b00, 0, 0, 0);

        // start_btn held through rst_n deassertion is ignored until re-pressed.
        @(negedge clk);
        rst_n = 1'b0;
        sw.start_btn = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step(1, 0, 0);
            chk_all($sformatf("held start %0d", k), 0, 2'b00, 0, 0, 0);
        end
        step(0, 0, 0);
        chk_all("held released", 0, 2'b00, 0, 0, 0);
        step(1, 0, 0);
        chk_all("held repress", 0, 2'b01, 1, 0, 0);
        for (int k = 0; k < 4; k++) step(0, 0, 0);
        chk_all("pre async-mid", 1, 2'b01, 1, 0, 0);

        // rst_n dropped between edges takes effect only at the next edge.
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("rst mid-cycle", 1, 2'b01, 1, 0, 0);
        @(posedge clk);
        #1;
        chk_all("rst at edge", 0, 2'b00, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
